// File: rtl/linear_driver.sv
// Sequencer around the Linear matmul engine: stream-in IN bytes, pulse trigger, latch OUT results, stream them out.
// Optional build macro LINEAR_DRIVER_CRELU_EN clamps each latched result to clamp(x >>> 6, 0, 127).
module linear_driver #(
  parameter int IN  = 256,
  parameter int OUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              lin_trigger,
  output logic [0:IN*8-1]   lin_x,
  input  logic              lin_finish,
  input  logic [0:OUT*16-1] lin_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              out_last,
  output logic              busy
);
  localparam int ICW = $clog2(IN);
  localparam int OCW = $clog2(OUT);
  localparam logic [ICW-1:0] I_LAST = ICW'(IN - 1);
  localparam logic [OCW-1:0] O_LAST = OCW'(OUT - 1);

  typedef enum logic [1:0] {LOAD, FIRE, WAIT, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [ICW-1:0]       icnt_q, icnt_d;
  logic [OCW-1:0]       ocnt_q, ocnt_d;
  logic [IN-1:0][7:0]   xbuf_q, xbuf_d;
  logic [OUT-1:0][15:0] rbuf_q, rbuf_d;
  logic [OUT-1:0][15:0] lat_val;

  for (genvar i = 0; i < IN; i++) begin : g_x
    assign lin_x[i*8 +: 8] = rst ? 8'd0 : xbuf_q[i];
  end

  for (genvar j = 0; j < OUT; j++) begin : g_lane
    logic signed [15:0] raw;
    assign raw = lin_out[j*16 +: 16];
`ifdef LINEAR_DRIVER_CRELU_EN
    logic signed [15:0] sh;
    assign sh = raw >>> 6;
    assign lat_val[j] = (sh < 16'sd0) ? 16'd0 : (sh > 16'sd127) ? 16'd127 : sh;
`else
    assign lat_val[j] = raw;
`endif
  end

  // All outputs are held at their idle values while rst is high, ahead of the reset edge.
  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    ocnt_d      = ocnt_q;
    xbuf_d      = xbuf_q;
    rbuf_d      = rbuf_q;
    in_ready    = 1'b0;
    lin_trigger = 1'b0;
    out_valid   = 1'b0;
    out_data    = 16'd0;
    out_last    = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      case (state_q)
        LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            xbuf_d[icnt_q] = in_data;
            if (icnt_q == I_LAST) begin
              icnt_d  = '0;
              state_d = FIRE;
            end else begin
              icnt_d = icnt_q + ICW'(1);
            end
          end
        end
        FIRE: begin
          lin_trigger = 1'b1;
          busy        = 1'b1;
          state_d     = WAIT;
        end
        WAIT: begin
          busy = 1'b1;
          if (lin_finish) begin
            rbuf_d  = lat_val;
            ocnt_d  = '0;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          busy      = 1'b1;
          out_valid = 1'b1;
          out_data  = rbuf_q[ocnt_q];
          out_last  = (ocnt_q == O_LAST);
          if (out_ready) begin
            if (out_last) begin
              ocnt_d  = '0;
              state_d = LOAD;
            end else begin
              ocnt_d = ocnt_q + OCW'(1);
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      icnt_q  <= '0;
      ocnt_q  <= '0;
      xbuf_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      ocnt_q  <= ocnt_d;
      xbuf_q  <= xbuf_d;
      rbuf_q  <= rbuf_d;
    end
  end
endmodule

// File: tb/tb_linear_driver.sv
// Directed bench for linear_driver with a Linear model: finish ~10 cycles after trigger, lin_out[j] = 100*j - 500.
module tb_linear_driver;
  localparam int IN  = 256;
  localparam int OUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'd0;
  logic              lin_trigger;
  logic [0:IN*8-1]   lin_x;
  logic              lin_finish;
  logic [0:OUT*16-1] lin_out;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0]       out_data;
  logic              out_last;
  logic              busy;

  int   n_pass = 0, n_total = 0, trig_cnt = 0, lat_cnt = 0;
  logic model_fin = 1'b0, force_fin = 1'b0, ov0 = 1'b0;

  linear_driver #(.IN(IN), .OUT(OUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lin_trigger(lin_trigger), .lin_x(lin_x), .lin_finish(lin_finish), .lin_out(lin_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign lin_finish = model_fin | force_fin;

  always_comb begin
    lin_out = '0;
    for (int j = 0; j < OUT; j++) lin_out[j*16 +: 16] = 16'(100 * j - 500);
    if (ov0) lin_out[0 +: 16] = 16'd32000;
  end

  always @(posedge clk) begin
    if (lin_trigger) trig_cnt <= trig_cnt + 1;
    if (rst) begin
      lat_cnt   <= 0;
      model_fin <= 1'b0;
    end else if (lin_trigger) begin
      lat_cnt   <= 10;
      model_fin <= 1'b0;
    end else if (lat_cnt > 0) begin
      lat_cnt   <= lat_cnt - 1;
      model_fin <= (lat_cnt == 1);
    end else begin
      model_fin <= 1'b0;
    end
  end

  function automatic logic [15:0] exp_el(input int j, input bit big);
`ifdef LINEAR_DRIVER_CRELU_EN
    int t [16] = '{0, 0, 0, 0, 0, 0, 1, 3, 4, 6, 7, 9, 10, 12, 14, 15};
    if (big && j == 0) return 16'd127;
    return 16'(t[j]);
`else
    if (big && j == 0) return 16'd32000;
    return 16'(100 * j - 500);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Performs n input handshakes carrying data first, first+1, ...; optional random valid gaps.
  task automatic do_load(input bit rnd, input int first, input int n);
    int  i = 0, c = 0;
    bit  hs;
    while (i < n && c < 8 * n + 20) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 8'(first + i);
      hs = in_valid & in_ready;
      tick();
      c++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    n_total++;
    if (i !== n) $display("FAIL load_count: got %0d handshakes, exp %0d", i, n);
    else n_pass++;
  endtask

  task automatic wait_drain(input string nm);
    int c = 0;
    while (!out_valid && c < 40) begin
      tick();
      c++;
    end
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL %s_finish_timeout: out_valid=%b after %0d cycles, exp 1", nm, out_valid, c);
    else n_pass++;
  endtask

  // Drains all OUT elements; bp selects the 1,0,0 out_ready pattern.
  task automatic drain(input string nm, input bit bp, input bit big);
    int          j = 0, c = 0, ph = 0;
    bit          hs, stall = 1'b0;
    logic [15:0] held = 16'd0;
    while (j < OUT && c < 200) begin
      out_ready = bp ? (ph % 3 == 0) : 1'b1;
      ph++;
      if (stall) begin
        n_total++;
        if (out_data !== held) $display("FAIL %s_hold: out_data=%0d, exp %0d", nm, $signed(out_data), $signed(held));
        else n_pass++;
      end
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL %s_valid[%0d]: out_valid=%b, exp 1", nm, j, out_valid);
      else n_pass++;
      n_total++;
      if (out_data !== exp_el(j, big))
        $display("FAIL %s_data[%0d]: out_data=%0d, exp %0d", nm, j, $signed(out_data), $signed(exp_el(j, big)));
      else n_pass++;
      n_total++;
      if (out_last !== (j == OUT - 1)) $display("FAIL %s_last[%0d]: out_last=%b, exp %b", nm, j, out_last, j == OUT - 1);
      else n_pass++;
      hs    = out_valid & out_ready;
      stall = out_valid & !out_ready;
      held  = out_data;
      tick();
      c++;
      if (hs) j++;
    end
    out_ready = 1'b0;
    n_total++;
    if (j !== OUT) $display("FAIL %s_count: got %0d elements, exp %0d", nm, j, OUT);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_return: in_ready=%b out_valid=%b busy=%b, exp 1 0 0", nm, in_ready, out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5a;
    tick(); tick();
    n_total++;
    if (in_ready !== 1'b0 || lin_trigger !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0)
      $display("FAIL rst_ctrl: in_ready=%b trig=%b busy=%b out_valid=%b out_last=%b, exp all 0",
               in_ready, lin_trigger, busy, out_valid, out_last);
    else n_pass++;
    n_total++;
    if (out_data !== 16'd0 || lin_x !== '0) $display("FAIL rst_data: out_data=%0d lin_x nonzero=%b, exp 0 0", out_data, lin_x != '0);
    else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || lin_x !== '0)
      $display("FAIL rst_release: in_ready=%b busy=%b lin_x nonzero=%b, exp 1 0 0", in_ready, busy, lin_x != '0);
    else n_pass++;
  endtask

  task automatic test_load_drain();
    int t0 = trig_cnt;
    do_load(1'b0, 0, IN);
    n_total++;
    if (lin_trigger !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || trig_cnt !== t0)
      $display("FAIL fire: trig=%b busy=%b in_ready=%b trigs=%0d, exp 1 1 0 %0d", lin_trigger, busy, in_ready, trig_cnt - t0, 0);
    else n_pass++;
    n_total++;
    if (lin_x[0*8 +: 8] !== 8'd0 || lin_x[127*8 +: 8] !== 8'd127 || lin_x[128*8 +: 8] !== 8'h80 || lin_x[255*8 +: 8] !== 8'hff)
      $display("FAIL lin_x: slots0/127/128/255=%h %h %h %h, exp 00 7f 80 ff",
               lin_x[0*8 +: 8], lin_x[127*8 +: 8], lin_x[128*8 +: 8], lin_x[255*8 +: 8]);
    else n_pass++;
    tick();
    n_total++;
    if (lin_trigger !== 1'b0 || trig_cnt !== t0 + 1 || busy !== 1'b1)
      $display("FAIL one_pulse: trig=%b trigs=%0d busy=%b, exp 0 1 1", lin_trigger, trig_cnt - t0, busy);
    else n_pass++;
    wait_drain("plain");
    drain("plain", 1'b0, 1'b0);
    n_total++;
    if (trig_cnt !== t0 + 1) $display("FAIL plain_trigs: got %0d, exp 1", trig_cnt - t0);
    else n_pass++;
  endtask

  // Random in_valid gaps, 1,0,0 out_ready, and a lin_out[0] override that is live only until the latch.
  task automatic test_backpressure();
    ov0 = 1'b1;
    do_load(1'b1, 0, IN);
    wait_drain("bp");
    ov0 = 1'b0;
    drain("bp", 1'b1, 1'b1);
  endtask

  task automatic test_ignore_finish();
    do_load(1'b0, 0, 50);
    force_fin = 1'b1;
    tick();
    force_fin = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL fin_load: out_valid=%b busy=%b in_ready=%b, exp 0 0 1", out_valid, busy, in_ready);
    else n_pass++;
    do_load(1'b0, 50, IN - 50);
    force_fin = 1'b1;
    tick();
    force_fin = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || lin_trigger !== 1'b0)
      $display("FAIL fin_fire: out_valid=%b busy=%b trig=%b, exp 0 1 0", out_valid, busy, lin_trigger);
    else n_pass++;
    n_total++;
    if (lin_x[49*8 +: 8] !== 8'd49 || lin_x[50*8 +: 8] !== 8'd50)
      $display("FAIL fin_lin_x: slots49/50=%0d %0d, exp 49 50", lin_x[49*8 +: 8], lin_x[50*8 +: 8]);
    else n_pass++;
    wait_drain("fin");
    drain("fin", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t0;
    do_load(1'b0, 0, 100);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'd100;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || lin_trigger !== 1'b0 || lin_x !== '0)
      $display("FAIL rst_load: in_ready=%b busy=%b trig=%b lin_x nonzero=%b, exp 1 0 0 0",
               in_ready, busy, lin_trigger, lin_x != '0);
    else n_pass++;
    t0 = trig_cnt;
    do_load(1'b0, 0, IN);
    n_total++;
    if (lin_x[100*8 +: 8] !== 8'd100 || lin_x[1*8 +: 8] !== 8'd1)
      $display("FAIL rst_reload: slots1/100=%0d %0d, exp 1 100", lin_x[1*8 +: 8], lin_x[100*8 +: 8]);
    else n_pass++;
    wait_drain("after_rst1");
    drain("after_rst1", 1'b0, 1'b0);
    do_load(1'b0, 0, IN);
    wait_drain("pre_rst2");
    out_ready = 1'b1;
    repeat (7) tick();
    n_total++;
    if (out_data !== exp_el(7, 1'b0) || out_valid !== 1'b1)
      $display("FAIL pre_rst2_el7: out_data=%0d valid=%b, exp %0d 1", $signed(out_data), out_valid, $signed(exp_el(7, 1'b0)));
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b1 || lin_x !== '0)
      $display("FAIL rst_drain: valid=%b last=%b data=%0d busy=%b in_ready=%b lin_x nonzero=%b, exp 0 0 0 0 1 0",
               out_valid, out_last, out_data, busy, in_ready, lin_x != '0);
    else n_pass++;
    repeat (20) tick();
    n_total++;
    if (trig_cnt !== t0 + 2 || out_valid !== 1'b0)
      $display("FAIL rst_quiet: trigs=%0d valid=%b, exp 2 0", trig_cnt - t0, out_valid);
    else n_pass++;
    do_load(1'b1, 0, IN);
    wait_drain("after_rst2");
    drain("after_rst2", 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_drain();
    test_backpressure();
    test_ignore_finish();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/linear_driver.md
# linear_driver

Initiator-side sequencer for the `Linear` matmul engine. It collects a streamed input vector into a packed buffer, fires a one-cycle trigger into `Linear`, waits for `finish`, latches the packed result vector, and streams results out one element at a time over a valid/ready port. It sits between the NNUE feature/accumulator stage and the `Linear` instance, so upstream logic never handles the wide packed buses.

## Interface
- `IN`, 256, number of signed 8-bit input elements (≥2).
- `OUT`, 16, number of signed 16-bit result elements (≥2).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream element valid.
- `in_ready` output 1: driver accepts an element this cycle.
- `in_data` input 8: signed input element, index 0 first.
- `lin_trigger` output 1: one-cycle start pulse to `Linear`.
- `lin_x` output IN*8: packed vector, declared `[0:IN*8-1]`; element i is at `lin_x[i*8 +: 8]`.
- `lin_finish` input 1: `Linear` completion flag.
- `lin_out` input OUT*16: packed results, declared `[0:OUT*16-1]`; element j is at `lin_out[j*16 +: 16]`.
- `out_valid` output 1: result element valid.
- `out_ready` input 1: downstream accepts the element.
- `out_data` output 16: result element j.
- `out_last` output 1: high with element OUT-1.
- `busy` output 1: high in FIRE, WAIT, and DRAIN.

## Operation
- FSM states: LOAD, FIRE, WAIT, DRAIN. Reset state is LOAD.
- LOAD
  - `in_ready=1`.
  - Each handshake (`in_valid & in_ready`) writes `in_data` into slot `icnt` and increments `icnt`.
  - The handshake at `icnt==IN-1` moves the FSM to FIRE and clears `icnt`.
- FIRE
  - `lin_trigger=1` for exactly one cycle.
  - Next state is WAIT.
- WAIT
  - `lin_finish` is sampled only in this state.
  - On `lin_finish=1`, all OUT elements of `lin_out` are latched into the result buffer, `ocnt` is cleared, and the FSM moves to DRAIN.
  - `lin_finish` seen in any other state is ignored.
- DRAIN
  - `out_valid=1`, `out_data=result[ocnt]`, `out_last=(ocnt==OUT-1)`.
  - Each handshake increments `ocnt`.
  - The handshake with `out_last` returns the FSM to LOAD.
- `lin_x` is driven directly from the input buffer register.
  - The buffer is written only in LOAD, so it is stable from FIRE until the next LOAD write.
- There is no overlap of loading and draining. `in_ready=0` outside LOAD.
- No arithmetic is performed on the data path except the optional CReLU (see Configuration). The latched values are the raw 16-bit `lin_out` elements.
- Reset (at any time, including mid-load, WAIT, or mid-drain):
  - FSM goes to LOAD, `icnt=ocnt=0`, input and result buffers are zeroed.
  - A partially loaded or undrained vector is discarded.
  - No trigger is issued.

## Timing
- Values while `rst` is high and on the first cycle after it:
  - `lin_trigger=0`, `out_valid=0`, `out_last=0`, `out_data=0`, `busy=0`, `lin_x=0`.
  - `in_ready` is gated low while `rst` is high, and is 1 on the first cycle after `rst` falls.
- The last input handshake at edge k gives `lin_trigger=1` during cycle k→k+1 only. WAIT begins at edge k+1.
- `lin_finish` sampled high at edge m gives `out_valid=1` with element 0 from edge m onward.
- An input handshake in the same cycle as a reset assertion is discarded.
- The final output handshake at edge d gives `in_ready=1` from edge d.
- Throughput: at most one element per cycle on each stream. Minimum turnaround is IN + 2 + (Linear latency) + OUT cycles.

## Configuration
- `LINEAR_DRIVER_CRELU_EN`
  - Defined: each latched result becomes clamp(`lin_out[j] >>> 6`, 0, 127), zero-extended to 16 bits.
    - The shift is arithmetic.
    - The clamp is applied once, at latch time in WAIT.
  - Undefined: results pass through as raw signed 16-bit values.
  - Handshake timing is identical in both builds.

## Test plan
All scenarios use IN=256, OUT=16. The bench model of `Linear` raises `lin_finish` 10 cycles after `lin_trigger` and drives `lin_out[j] = 100*j - 500`.

- Load x[i]=i for i<128 and x[i+128]=i-128 (signed) with `in_valid` held high.
  - `lin_x[0*8+:8]=0`, `lin_x[127*8+:8]=127`, `lin_x[128*8+:8]=-128`.
  - Exactly one `lin_trigger` pulse, one cycle after the 256th handshake.
- Drain without CReLU, `out_ready` held high.
  - 16 consecutive elements: `out_data` = -500, -400, …, 1000.
  - `out_last` is high only on 1000.
  - `in_ready=1` on the next cycle.
- Drain with `LINEAR_DRIVER_CRELU_EN`.
  - Elements j=0..5 give 0, 0, 0, 0, 0, 0.
  - j=6 (100) gives 1; j=15 (1000) gives 15.
  - Force `lin_out[0]=32000`: it gives 127.
- Backpressure: toggle `out_ready` 1,0,0,1,… and `in_valid` randomly.
  - Element order and count are unchanged.
  - `out_data` holds its value while `out_ready=0`.
  - No element is lost or duplicated.
- Pulse `lin_finish` during LOAD and during FIRE.
  - It is ignored; no state change and no `out_valid`.
- Assert `rst` for 1 cycle at input handshake 100, then at drain element 7.
  - Each time the FSM returns to LOAD, with outputs at their reset values and no trigger.
  - A full subsequent load/compute/drain cycle completes correctly.
